aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Multi-cycle controller that drives the register-file/execute datapath through a complete AES block operation. It accepts one command naming a state register, a key register, a destination register, a direction and a key length. It then issues the round-key-add, key-expansion and round micro-ops in order, one at a time, with a valid/ready issue handshake and a completion strobe from execute. It sits ahead of the register-file stage and supplies its rs1/rs2/rd/round/finalRound/keyAssist/encryption fields while a block instruction is in flight.

## Interface
Parameters:
- NREG_W, 5, register index width
- ROUND_W, 5, round field width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  command valid
- startReady  out  1  high in IDLE only; command accepted when start && startReady
- encryptionIn  in  1  1 = encrypt, 0 = decrypt
- keyLen  in  2  0 = AES-128 (N=10), 1 = AES-192 (N=12), 2 = AES-256 (N=14), 3 = reserved
- stateReg, keyReg, destReg  in  NREG_W each  command operands
- abort  in  1  cancel in-flight command
- issueValid  out  1  micro-op fields valid
- issueReady  in  1  datapath accepts micro-op
- rs1, rs2, rd  out  NREG_W each  micro-op register fields
- round  out  ROUND_W  round number of micro-op
- finalRound, keyAssist, encryption  out  1 each  micro-op control bits
- execDone  in  1  one-cycle strobe: outstanding micro-op has written back
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, command complete
- cmdError  out  1  one-cycle pulse, reserved keyLen rejected

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Internal state: round counter r (ROUND_W bits), phase bit (KEY/RND), latched command.
- IDLE: on start with keyLen != 3, latch the command, set r=0, phase=RND, go to ISSUE. With keyLen = 3, pulse cmdError next cycle and stay in IDLE.
- Micro-op order: r=0 RND, then for r=1..N a KEY op followed by a RND op. Total 2N+1 ops (21/25/29).
- r=0 RND (initial add): rs1=stateReg, rs2=keyReg, rd=destReg, keyAssist=0.
- KEY op: rs1=keyReg, rs2=keyReg, rd=keyReg, keyAssist=1, round=r.
- RND op (r≥1): rs1=destReg, rs2=keyReg, rd=destReg, keyAssist=0, round=r. finalRound=1 only when r==N.
- encryption = latched encryptionIn on every op.
- ISSUE: issueValid=1; fields held stable until issueReady. On handshake go to WAIT.
- WAIT: on execDone, advance (RND→KEY with r+1, KEY→RND). Go to ISSUE, or to DONE if the completed op was RND with r==N.
- DONE: done=1 for one cycle, then IDLE.
- execDone outside WAIT is ignored. At most one micro-op is outstanding.
- abort in ISSUE/WAIT/DONE: go to IDLE next cycle, no done pulse. A later execDone is ignored.
- start while busy is not accepted (startReady=0).

## Timing
- Reset values: state IDLE, startReady=1, all other outputs 0 (fields 0).
- Command accepted at edge T → issueValid high in cycle T+1.
- Best case per micro-op: 2 cycles (ISSUE with issueReady=1, then WAIT with execDone the same cycle).
- Best-case total for AES-128: first issue T+1, last execDone T+42, done high T+43, startReady high T+44.
- issueReady low stalls in ISSUE indefinitely with fields stable.
- abort and execDone in the same cycle: abort wins.
- Asynchronous reset mid-operation: immediate return to reset values.

## Configuration
- AES_SEQ_CYCLE_COUNT_EN defined: adds output cycleCount (16 bits). It counts cycles from acceptance to done, saturates at 16'hFFFF, holds after done, and clears on the next acceptance. Reset value 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package crypto_seq_pkg holds:
  - state enum seq_state_t
  - keyLen encodings
  - round-count constants NR_128=10, NR_192=12, NR_256=14
  - function keylen_to_nr
- Sub-module aes_seq_opgen: combinational mapping of (phase, r, N, latched command) to rs1/rs2/rd/round/finalRound/keyAssist/encryption. The FSM, counter and handshake stay in the top module.

## Test plan
- AES-128 encrypt (stateReg=1, keyReg=2, destReg=3), issueReady and execDone always responsive:
  - 21 ops issued.
  - First op rs1=1, rs2=2, rd=3, round=0.
  - Op 20 is KEY round=10; op 21 is RND round=10 with finalRound=1.
  - done at T+43.
- AES-256 decrypt with issueReady low for 5 cycles on op 3:
  - Fields stable during the stall.
  - 29 ops total; encryption=0 throughout; done once.
- keyLen=3 start → cmdError one pulse, no issueValid, busy stays 0.
- abort during WAIT of op 7, then execDone next cycle → IDLE, no done. A new command restarts at round 0.
- Asynchronous reset asserted mid-ISSUE → outputs return to reset values without a clock edge. startReady=1 after release.
- AES_SEQ_CYCLE_COUNT_EN build, AES-128 best case → cycleCount=43 after done.

Source files
------------

// File: rtl/crypto_seq_pkg.sv
// Shared definitions for the AES block-operation sequencer: FSM state codes,
// keyLen encodings, round counts and the keyLen -> round-count mapping.
package crypto_seq_pkg;

    // FSM state codes (kept as plain constants for legacy tools)
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_ISSUE = 2'd1;
    localparam seq_state_t ST_WAIT  = 2'd2;
    localparam seq_state_t ST_DONE  = 2'd3;

    // keyLen encodings
    localparam logic [1:0] KEYLEN_128  = 2'd0;
    localparam logic [1:0] KEYLEN_192  = 2'd1;
    localparam logic [1:0] KEYLEN_256  = 2'd2;
    localparam logic [1:0] KEYLEN_RSVD = 2'd3;

    // Number of rounds per key length
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    // Micro-op phase within a round
    localparam logic PHASE_RND = 1'b0;
    localparam logic PHASE_KEY = 1'b1;

    function automatic logic [4:0] keylen_to_nr(input logic [1:0] key_len);
        case (key_len)
            KEYLEN_128: return 5'(NR_128);
            KEYLEN_192: return 5'(NR_192);
            KEYLEN_256: return 5'(NR_256);
            default:    return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_seq_opgen.sv
// Combinational micro-op field generator: maps phase, round counter, round
// count and the latched command onto register/round/control fields.
module aes_seq_opgen #(
    parameter int unsigned NREG_W  = 5,
    parameter int unsigned ROUND_W = 5
) (
    input  logic               phase,
    input  logic [ROUND_W-1:0] r,
    input  logic [ROUND_W-1:0] nr,
    input  logic [NREG_W-1:0]  state_reg,
    input  logic [NREG_W-1:0]  key_reg,
    input  logic [NREG_W-1:0]  dest_reg,
    input  logic               enc,
    output logic [NREG_W-1:0]  rs1,
    output logic [NREG_W-1:0]  rs2,
    output logic [NREG_W-1:0]  rd,
    output logic [ROUND_W-1:0] round,
    output logic               final_round,
    output logic               key_assist,
    output logic               encryption
);
    import crypto_seq_pkg::*;

    // Default to a round op; key-expansion and the initial add override
    always_comb begin
        rs1         = dest_reg;
        rs2         = key_reg;
        rd          = dest_reg;
        round       = r;
        final_round = 1'b0;
        key_assist  = 1'b0;
        encryption  = enc;
        if (phase == PHASE_KEY) begin
            rs1        = key_reg;
            rd         = key_reg;
            key_assist = 1'b1;
        end else begin
            // Round 0 is the initial key add on the source state
            if (r == '0) rs1 = state_reg;
            final_round = (r == nr);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES block-operation sequencer: accepts one command and issues the
// 2N+1 round-key-add / key-expansion / round micro-ops one at a time.
// Optional feature: define AES_SEQ_CYCLE_COUNT_EN to add the 16-bit
// cycleCount output (acceptance-to-done cycle count, saturating).
module aes_round_sequencer #(
    parameter int unsigned NREG_W  = 5,
    parameter int unsigned ROUND_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               startReady,
    input  logic               encryptionIn,
    input  logic [1:0]         keyLen,
    input  logic [NREG_W-1:0]  stateReg,
    input  logic [NREG_W-1:0]  keyReg,
    input  logic [NREG_W-1:0]  destReg,
    input  logic               abort,
    output logic               issueValid,
    input  logic               issueReady,
    output logic [NREG_W-1:0]  rs1,
    output logic [NREG_W-1:0]  rs2,
    output logic [NREG_W-1:0]  rd,
    output logic [ROUND_W-1:0] round,
    output logic               finalRound,
    output logic               keyAssist,
    output logic               encryption,
    input  logic               execDone,
    output logic               busy,
    output logic               done,
`ifdef AES_SEQ_CYCLE_COUNT_EN
    output logic [15:0]        cycleCount,
`endif
    output logic               cmdError
);
    import crypto_seq_pkg::*;

    seq_state_t         state_q, state_d;
    logic               phase_q, phase_d;
    logic [ROUND_W-1:0] r_q, r_d;
    logic [ROUND_W-1:0] nr_q;
    logic [NREG_W-1:0]  state_reg_q, key_reg_q, dest_reg_q;
    logic               enc_q;
    logic               cmd_error_q;
    logic               accept, reject;

    logic [NREG_W-1:0]  op_rs1, op_rs2, op_rd;
    logic [ROUND_W-1:0] op_round;
    logic               op_final, op_key_assist, op_enc;

    assign accept = start && (state_q == ST_IDLE) && (keyLen != KEYLEN_RSVD);
    assign reject = start && (state_q == ST_IDLE) && (keyLen == KEYLEN_RSVD);

    // Next-state logic: issue handshake, completion advance and abort
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        r_d     = r_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    phase_d = PHASE_RND;
                    r_d     = '0;
                end
            end
            ST_ISSUE: begin
                if (abort) state_d = ST_IDLE;
                else if (issueReady) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (execDone) begin
                    if (phase_q == PHASE_KEY) begin
                        phase_d = PHASE_RND;
                        state_d = ST_ISSUE;
                    end else if (r_q == nr_q) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d = PHASE_KEY;
                        r_d     = r_q + ROUND_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, round counter and phase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PHASE_RND;
            r_q         <= '0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            r_q         <= r_d;
            cmd_error_q <= reject;
        end
    end

    // Latch the command operands on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nr_q        <= '0;
            state_reg_q <= '0;
            key_reg_q   <= '0;
            dest_reg_q  <= '0;
            enc_q       <= 1'b0;
        end else if (accept) begin
            nr_q        <= ROUND_W'(keylen_to_nr(keyLen));
            state_reg_q <= stateReg;
            key_reg_q   <= keyReg;
            dest_reg_q  <= destReg;
            enc_q       <= encryptionIn;
        end
    end

    aes_seq_opgen #(
        .NREG_W  (NREG_W),
        .ROUND_W (ROUND_W)
    ) u_opgen (
        .phase       (phase_q),
        .r           (r_q),
        .nr          (nr_q),
        .state_reg   (state_reg_q),
        .key_reg     (key_reg_q),
        .dest_reg    (dest_reg_q),
        .enc         (enc_q),
        .rs1         (op_rs1),
        .rs2         (op_rs2),
        .rd          (op_rd),
        .round       (op_round),
        .final_round (op_final),
        .key_assist  (op_key_assist),
        .encryption  (op_enc)
    );

    // Fields are driven only while a micro-op is offered, zero otherwise
    assign issueValid = (state_q == ST_ISSUE);
    assign rs1        = issueValid ? op_rs1 : '0;
    assign rs2        = issueValid ? op_rs2 : '0;
    assign rd         = issueValid ? op_rd : '0;
    assign round      = issueValid ? op_round : '0;
    assign finalRound = issueValid && op_final;
    assign keyAssist  = issueValid && op_key_assist;
    assign encryption = issueValid && op_enc;

    assign startReady = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    // An abort arriving in DONE suppresses the completion pulse
    assign done       = (state_q == ST_DONE) && !abort;
    assign cmdError   = cmd_error_q;

`ifdef AES_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt_q;

    // Count from acceptance up to the DONE cycle, saturating, hold afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else if (accept) begin
            cycle_cnt_q <= 16'd1;
        end else if ((state_q == ST_ISSUE || state_q == ST_WAIT) &&
                     (cycle_cnt_q != 16'hFFFF)) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end
    end

    assign cycleCount = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer. Expected micro-op fields are
// generated per command into a scoreboard queue and popped on each issue.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       startReady;
    logic       encryptionIn;
    logic [1:0] keyLen;
    logic [4:0] stateReg, keyReg, destReg;
    logic       abort;
    logic       issueValid;
    logic       issueReady;
    logic [4:0] rs1, rs2, rd;
    logic [4:0] round;
    logic       finalRound, keyAssist, encryption;
    logic       execDone;
    logic       busy, done, cmdError;
`ifdef AES_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycleCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // {rs1, rs2, rd, round, finalRound, keyAssist, encryption}
    logic [22:0] sb[$];

    always #5 clk = ~clk;

    aes_round_sequencer #(
        .NREG_W  (5),
        .ROUND_W (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .startReady   (startReady),
        .encryptionIn (encryptionIn),
        .keyLen       (keyLen),
        .stateReg     (stateReg),
        .keyReg       (keyReg),
        .destReg      (destReg),
        .abort        (abort),
        .issueValid   (issueValid),
        .issueReady   (issueReady),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .round        (round),
        .finalRound   (finalRound),
        .keyAssist    (keyAssist),
        .encryption   (encryption),
        .execDone     (execDone),
        .busy         (busy),
        .done         (done),
`ifdef AES_SEQ_CYCLE_COUNT_EN
        .cycleCount   (cycleCount),
`endif
        .cmdError     (cmdError)
    );

    function automatic logic [22:0] fields();
        return {rs1, rs2, rd, round, finalRound, keyAssist, encryption};
    endfunction

    // Reference op sequence: r=0 RND, then KEY/RND pairs for r=1..N
    function automatic void push_block(input logic [1:0] kl, input logic enc,
                                       input logic [4:0] sr, input logic [4:0] kr,
                                       input logic [4:0] dr);
        int n;
        n = (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
        for (int i = 0; i <= 2 * n; i++) begin
            int r;
            logic [4:0] rr;
            r  = (i + 1) / 2;
            rr = 5'(r);
            if (i == 0) sb.push_back({sr, kr, dr, 5'd0, 1'b0, 1'b0, enc});
            else if (i % 2 == 1) sb.push_back({kr, kr, kr, rr, 1'b0, 1'b1, enc});
            else sb.push_back({dr, kr, dr, rr, (r == n), 1'b0, enc});
        end
    endfunction

    // Present a command for one edge; the following negedge is cycle T+1
    task automatic start_cmd(input logic [1:0] kl, input logic enc, input logic [4:0] sr,
                             input logic [4:0] kr, input logic [4:0] dr);
        @(negedge clk);
        start        = 1'b1;
        keyLen       = kl;
        encryptionIn = enc;
        stateReg     = sr;
        keyReg       = kr;
        destReg      = dr;
        issueReady   = 1'b1;
        execDone     = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        obs = fields();
        n_cmp++;
        if ({startReady, issueValid, busy, done, cmdError} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 10000",
                     {startReady, issueValid, busy, done, cmdError});
        end
        n_cmp++;
        if (obs !== 23'd0) begin
            n_err++;
            $display("FAIL reset_fields: got %h want 0", obs);
        end
`ifdef AES_SEQ_CYCLE_COUNT_EN
        n_cmp++;
        if (cycleCount !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cycle_count: got %0d want 0", cycleCount);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({startReady, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: got %b want 10", {startReady, busy});
        end
    endtask

    task automatic test_aes128_best();
        logic [22:0] obs, exp;
        int ops = 0, dn = 0, t_done = 0;
        bit fin = 0;
        sb.delete();
        push_block(2'd0, 1'b1, 5'd1, 5'd2, 5'd3);
        start_cmd(2'd0, 1'b1, 5'd1, 5'd2, 5'd3);
        for (int k = 1; k <= 80 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (issueValid) begin
                obs = fields();
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL aes128_extra_op: got %h want none", obs);
                end else begin
                    exp = sb.pop_front();
                    if (obs !== exp) begin
                        n_err++;
                        $display("FAIL aes128_op%0d: got %h want %h", ops + 1, obs, exp);
                    end
                end
                ops++;
            end
            if (done) begin
                dn++;
                t_done = k;
                fin = 1;
`ifdef AES_SEQ_CYCLE_COUNT_EN
                n_cmp++;
                if (cycleCount !== 16'd43) begin
                    n_err++;
                    $display("FAIL aes128_cycle_count: got %0d want 43", cycleCount);
                end
`endif
            end
            execDone = busy && !issueValid && !done;
        end
        n_cmp++;
        if (ops != 21) begin
            n_err++;
            $display("FAIL aes128_op_count: got %0d want 21", ops);
        end
        n_cmp++;
        if (t_done != 43) begin
            n_err++;
            $display("FAIL aes128_done_time: got T+%0d want T+43", t_done);
        end
        @(negedge clk);
        execDone = 1'b0;
        n_cmp++;
        if ({startReady, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL aes128_idle_after: got %b want 100", {startReady, busy, done});
        end
`ifdef AES_SEQ_CYCLE_COUNT_EN
        n_cmp++;
        if (cycleCount !== 16'd43) begin
            n_err++;
            $display("FAIL aes128_cycle_hold: got %0d want 43", cycleCount);
        end
`endif
    endtask

    task automatic test_aes256_stall();
        logic [22:0] obs, exp, held;
        int ops = 0, dn = 0, stall = 0;
        bit fin = 0;
        held = '0;
        sb.delete();
        push_block(2'd2, 1'b0, 5'd7, 5'd8, 5'd9);
        start_cmd(2'd2, 1'b0, 5'd7, 5'd8, 5'd9);
        for (int k = 1; k <= 120 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (issueValid) begin
                obs = fields();
                if (ops == 2 && stall < 5) begin
                    if (stall == 0) begin
                        held = obs;
                    end else begin
                        n_cmp++;
                        if (obs !== held) begin
                            n_err++;
                            $display("FAIL stall_stable%0d: got %h want %h", stall, obs, held);
                        end
                    end
                    issueReady = 1'b0;
                    stall++;
                end else begin
                    issueReady = 1'b1;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL aes256_extra_op: got %h want none", obs);
                    end else begin
                        exp = sb.pop_front();
                        if (obs !== exp) begin
                            n_err++;
                            $display("FAIL aes256_op%0d: got %h want %h", ops + 1, obs, exp);
                        end
                    end
                    ops++;
                end
            end
            if (done) begin
                dn++;
                fin = 1;
            end
            execDone = busy && !issueValid && !done;
        end
        n_cmp++;
        if (ops != 29 || stall != 5) begin
            n_err++;
            $display("FAIL aes256_op_count: got ops=%0d stall=%0d want 29/5", ops, stall);
        end
        @(negedge clk);
        execDone = 1'b0;
        n_cmp++;
        if (dn != 1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL aes256_done_once: got count=%0d done=%b want 1/0", dn, done);
        end
    endtask

    task automatic test_reserved_keylen();
        start_cmd(2'd3, 1'b1, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({cmdError, issueValid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL rsvd_pulse: got %b want 100", {cmdError, issueValid, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({cmdError, issueValid, busy, startReady} !== 4'b0001) begin
            n_err++;
            $display("FAIL rsvd_after: got %b want 0001",
                     {cmdError, issueValid, busy, startReady});
        end
    endtask

    task automatic test_abort();
        logic [22:0] obs, exp;
        int ops = 0;
        bit hit = 0;
        sb.delete();
        push_block(2'd0, 1'b1, 5'd4, 5'd5, 5'd6);
        start_cmd(2'd0, 1'b1, 5'd4, 5'd5, 5'd6);
        for (int k = 1; k <= 40 && !hit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (issueValid) begin
                obs = fields();
                exp = (sb.size() != 0) ? sb.pop_front() : 23'h7FFFFF;
                n_cmp++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL abort_op%0d: got %h want %h", ops + 1, obs, exp);
                end
                ops++;
            end
            if (busy && !issueValid && !done && ops == 7) begin
                abort    = 1'b1;
                execDone = 1'b0;
                hit      = 1;
            end else begin
                execDone = busy && !issueValid && !done;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL abort_reach_op7: got ops=%0d want wait of op 7", ops);
        end
        @(negedge clk);
        abort    = 1'b0;
        execDone = 1'b1;
        n_cmp++;
        if ({busy, done, startReady} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_idle: got %b want 001", {busy, done, startReady});
        end
        @(negedge clk);
        execDone = 1'b0;
        n_cmp++;
        if ({busy, done, issueValid} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_late_exec: got %b want 000", {busy, done, issueValid});
        end
        sb.delete();
        push_block(2'd1, 1'b1, 5'd10, 5'd11, 5'd12);
        start_cmd(2'd1, 1'b1, 5'd10, 5'd11, 5'd12);
        @(negedge clk);
        start = 1'b0;
        obs = fields();
        exp = sb.pop_front();
        n_cmp++;
        if (issueValid !== 1'b1 || obs !== exp) begin
            n_err++;
            $display("FAIL restart_first_op: got v=%b %h want v=1 %h", issueValid, obs, exp);
        end
        // abort while offering, handshake suppressed by the same-cycle abort
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({busy, issueValid} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_in_issue: got %b want 00", {busy, issueValid});
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] obs;
        start_cmd(2'd2, 1'b1, 5'd13, 5'd14, 5'd15);
        @(negedge clk);
        start      = 1'b0;
        issueReady = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({issueValid, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL areset_setup: got %b want 11", {issueValid, busy});
        end
        #1 reset = 1'b1;
        #1;
        obs = fields();
        n_cmp++;
        if ({startReady, issueValid, busy, done, cmdError} !== 5'b10000 || obs !== 23'd0) begin
            n_err++;
            $display("FAIL areset_immediate: got ctrl=%b fields=%h want 10000/0",
                     {startReady, issueValid, busy, done, cmdError}, obs);
        end
        @(negedge clk);
        reset      = 1'b0;
        issueReady = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({startReady, busy, issueValid} !== 3'b100) begin
            n_err++;
            $display("FAIL areset_release: got %b want 100", {startReady, busy, issueValid});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        encryptionIn = 1'b0;
        keyLen       = 2'd0;
        stateReg     = '0;
        keyReg       = '0;
        destReg      = '0;
        abort        = 1'b0;
        issueReady   = 1'b1;
        execDone     = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_aes128_best();
        test_aes256_stall();
        test_reserved_keylen();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
